// File: rtl/core_input_buf.sv
// ---------------------------------------------------------------------------
// core_input_buf
//
// Core-side receiver for the engine->core block-input bus.  The engine fills
// one of four thread slots (slot = {input_seq,input_ctx}) with sixteen 32-bit
// words and then marks the block complete.  Completed blocks are offered to
// the core's MD5 FSM round-robin.  The core takes a block with out_start,
// reads its words through the registered read port, and releases the slot
// with out_done.
//
// Ports
//   CLK              clock
//   RST              synchronous active-high reset
//   wr_en            data word valid
//   din              data word
//   wr_addr          word index 0..15 within the block
//   blk_op           block op, latched with set_input_ready
//   input_ctx        slot select, low bit
//   input_seq        slot select, high bit
//   set_input_ready  block complete for the selected slot
//   ready[3:0]       ready[s]=1 when slot s is FREE
//   out_valid        a FULL slot is offered to the core
//   out_slot         offered slot number
//   out_blk_op       block op of the offered slot
//   out_start        core takes the offered slot
//   rd_slot          read slot (also the slot released by out_done)
//   rd_addr          read word index
//   rd_data          RAM[{rd_slot,rd_addr}], one cycle latency
//   out_done         core releases slot rd_slot
//   err              sticky protocol error
// ---------------------------------------------------------------------------
module core_input_buf #(
    parameter int BLK_OP_W = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                wr_en,
    input  logic [31:0]         din,
    input  logic [3:0]          wr_addr,
    input  logic [BLK_OP_W-1:0] blk_op,
    input  logic                input_ctx,
    input  logic                input_seq,
    input  logic                set_input_ready,
    output logic [3:0]          ready,
    output logic                out_valid,
    output logic [1:0]          out_slot,
    output logic [BLK_OP_W-1:0] out_blk_op,
    input  logic                out_start,
    input  logic [1:0]          rd_slot,
    input  logic [3:0]          rd_addr,
    output logic [31:0]         rd_data,
    input  logic                out_done,
    output logic                err
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_LOADING = 2'd1,
        S_FULL    = 2'd2,
        S_BUSY    = 2'd3
    } slot_state_t;

    slot_state_t         state_q [4];
    slot_state_t         state_d [4];
    logic [4:0]          cnt_q   [4];
    logic [4:0]          cnt_d   [4];
    logic [BLK_OP_W-1:0] op_q    [4];
    logic [BLK_OP_W-1:0] op_d    [4];

    logic [1:0]          in_slot;
    logic                ram_we;
    logic                err_set;
    logic [1:0]          last_start;
    logic                pick_valid;
    logic [1:0]          pick_slot;

    logic [31:0]         mem [64];

    assign in_slot = {input_seq, input_ctx};

    // Per-slot next state.  Every event checks the registered state of its
    // slot, so events on different slots in one cycle never interfere.  The
    // completion check uses the counter including a same-cycle write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ram_we  = 1'b0;
        err_set = 1'b0;

        if (wr_en) begin
            if (state_q[in_slot] == S_FREE || state_q[in_slot] == S_LOADING) begin
                ram_we           = 1'b1;
                state_d[in_slot] = S_LOADING;
                if (cnt_q[in_slot] != 5'd16) begin
                    cnt_d[in_slot] = cnt_q[in_slot] + 5'd1;
                end
            end else begin
                err_set = 1'b1;
            end
        end

        if (set_input_ready) begin
            if (state_q[in_slot] == S_LOADING && cnt_d[in_slot] == 5'd16) begin
                state_d[in_slot] = S_FULL;
                op_d[in_slot]    = blk_op;
            end else begin
                err_set = 1'b1;
            end
        end

        // The offered slot is always FULL, because an offer is held until taken.
        if (out_start) begin
            if (out_valid) begin
                state_d[out_slot] = S_BUSY;
            end else begin
                err_set = 1'b1;
            end
        end

        if (out_done) begin
            if (state_q[rd_slot] == S_BUSY) begin
                state_d[rd_slot] = S_FREE;
                cnt_d[rd_slot]   = 5'd0;
            end else begin
                err_set = 1'b1;
            end
        end
    end

    // Slot registers, ready flags and the sticky error.  ready is taken from
    // the next state so it tracks the slot state with no extra delay.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= S_FREE;
                cnt_q[i]   <= 5'd0;
                op_q[i]    <= '0;
            end
            ready <= 4'hF;
            err   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                op_q[i]    <= op_d[i];
                ready[i]   <= (state_d[i] == S_FREE);
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Round-robin pick: search last_start+1, +2, +3, then last_start itself.
    // Iterating from the farthest candidate lets the nearest one win.
    always_comb begin
        pick_valid = 1'b0;
        pick_slot  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (state_q[last_start + 2'(k)] == S_FULL) begin
                pick_valid = 1'b1;
                pick_slot  = last_start + 2'(k);
            end
        end
    end

    // Offer register.  An offer stays put until taken; after a start the
    // register empties for one cycle and the next pick happens from there.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid  <= 1'b0;
            out_slot   <= 2'd0;
            out_blk_op <= '0;
            last_start <= 2'd3;
        end else if (out_valid && out_start) begin
            out_valid  <= 1'b0;
            last_start <= out_slot;
        end else if (!out_valid && pick_valid) begin
            out_valid  <= 1'b1;
            out_slot   <= pick_slot;
            out_blk_op <= op_q[pick_slot];
        end
    end

    // Block storage.  Contents survive reset; only writes into a FREE or
    // LOADING slot land.
    always_ff @(posedge CLK) begin
        if (ram_we && !RST) begin
            mem[{in_slot, wr_addr}] <= din;
        end
    end

    // Registered read port; a same-cycle write to the address returns old data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data <= 32'd0;
        end else begin
            rd_data <= mem[{rd_slot, rd_addr}];
        end
    end

endmodule

// File: tb/tb_core_input_buf.sv
// ---------------------------------------------------------------------------
// tb_core_input_buf
//
// Self-checking bench for core_input_buf: a directed vector table for the
// basic load/offer/read/release flow, hand-written sequences for the
// multi-cycle corner cases, and a randomized phase compared every cycle
// against a slot-level behavioural model.
// ---------------------------------------------------------------------------
module tb_core_input_buf;

    localparam int OPW = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic           wr_en;
    logic [31:0]    din;
    logic [3:0]     wr_addr;
    logic [OPW-1:0] blk_op;
    logic           input_ctx;
    logic           input_seq;
    logic           set_input_ready;
    logic [3:0]     ready;
    logic           out_valid;
    logic [1:0]     out_slot;
    logic [OPW-1:0] out_blk_op;
    logic           out_start;
    logic [1:0]     rd_slot;
    logic [3:0]     rd_addr;
    logic [31:0]    rd_data;
    logic           out_done;
    logic           err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    core_input_buf #(.BLK_OP_W(OPW)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .wr_en           (wr_en),
        .din             (din),
        .wr_addr         (wr_addr),
        .blk_op          (blk_op),
        .input_ctx       (input_ctx),
        .input_seq       (input_seq),
        .set_input_ready (set_input_ready),
        .ready           (ready),
        .out_valid       (out_valid),
        .out_slot        (out_slot),
        .out_blk_op      (out_blk_op),
        .out_start       (out_start),
        .rd_slot         (rd_slot),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .out_done        (out_done),
        .err             (err)
    );

    // Reference model.  Slot states: 0 free, 1 loading, 2 full, 3 busy.
    // A new offer appears in the cycle after a slot is seen FULL with no
    // offer pending, and the offer register is empty for one cycle after
    // each start.
    int          m_st  [4];
    int          m_cnt [4];
    int          m_ps  [4];
    logic [3:0]  m_op  [4];
    logic [31:0] m_mem [64];
    bit          m_known [64];
    bit          m_err;
    logic [3:0]  m_ready;
    bit          m_valid;
    int          m_oslot;
    logic [3:0]  m_oop;
    int          m_last;
    logic [31:0] m_rd;
    bit          m_rd_known;
    int          m_s;
    bit          m_found;

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                m_st[i]  = 0;
                m_cnt[i] = 0;
                m_op[i]  = 4'd0;
            end
            m_err      = 1'b0;
            m_ready    = 4'hF;
            m_valid    = 1'b0;
            m_oslot    = 0;
            m_oop      = 4'd0;
            m_last     = 3;
            m_rd       = 32'd0;
            m_rd_known = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) m_ps[i] = m_st[i];
            m_s        = int'({input_seq, input_ctx});
            m_rd       = m_mem[{rd_slot, rd_addr}];
            m_rd_known = m_known[{rd_slot, rd_addr}];
            if (wr_en) begin
                if (m_ps[m_s] <= 1) begin
                    m_mem[{input_seq, input_ctx, wr_addr}]   = din;
                    m_known[{input_seq, input_ctx, wr_addr}] = 1'b1;
                    m_st[m_s] = 1;
                    if (m_cnt[m_s] < 16) m_cnt[m_s] = m_cnt[m_s] + 1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (set_input_ready) begin
                if (m_ps[m_s] == 1 && m_cnt[m_s] == 16) begin
                    m_op[m_s] = blk_op;
                    m_st[m_s] = 2;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (out_start) begin
                if (m_valid) m_st[m_oslot] = 3;
                else         m_err = 1'b1;
            end
            if (out_done) begin
                if (m_ps[rd_slot] == 3) begin
                    m_st[rd_slot]  = 0;
                    m_cnt[rd_slot] = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_valid && out_start) begin
                m_valid = 1'b0;
                m_last  = m_oslot;
            end else if (!m_valid) begin
                m_found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!m_found && m_ps[(m_last + k) % 4] == 2) begin
                        m_found = 1'b1;
                        m_valid = 1'b1;
                        m_oslot = (m_last + k) % 4;
                        m_oop   = m_op[m_oslot];
                    end
                end
            end
            for (int i = 0; i < 4; i++) m_ready[i] = (m_st[i] == 0);
        end
    end

    typedef struct packed {
        bit        wr;
        bit [1:0]  slot;
        bit [3:0]  addr;
        bit [31:0] din;
        bit        sir;
        bit [3:0]  op;
        bit        st;
        bit        dn;
        bit [1:0]  rslot;
        bit [3:0]  raddr;
        bit [3:0]  e_ready;
        bit        e_valid;
        bit [1:0]  e_oslot;
        bit [3:0]  e_op;
        bit        e_err;
        bit        chk_rd;
        bit [31:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic driveIdle();
        wr_en           = 1'b0;
        din             = 32'd0;
        wr_addr         = 4'd0;
        blk_op          = 4'd0;
        input_ctx       = 1'b0;
        input_seq       = 1'b0;
        set_input_ready = 1'b0;
        out_start       = 1'b0;
        out_done        = 1'b0;
        rd_slot         = 2'd0;
        rd_addr         = 4'd0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".ready"}, {28'd0, ready}, {28'd0, m_ready});
        checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
        if (m_valid) begin
            checkOutput({tag, ".out_slot"}, {30'd0, out_slot}, 32'(m_oslot));
            checkOutput({tag, ".out_blk_op"}, {28'd0, out_blk_op}, {28'd0, m_oop});
        end
        if (m_rd_known) begin
            checkOutput({tag, ".rd_data"}, rd_data, m_rd);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wr_en           = v.wr;
        {input_seq, input_ctx} = v.slot;
        wr_addr         = v.addr;
        din             = v.din;
        set_input_ready = v.sir;
        blk_op          = v.op;
        out_start       = v.st;
        out_done        = v.dn;
        rd_slot         = v.rslot;
        rd_addr         = v.raddr;
        tick();
        driveIdle();
    endtask

    task automatic doReset();
        driveIdle();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic loadSlot(input int s, input logic [31:0] base, input logic [3:0] op,
                            input int nwords, input bit sir_last);
        for (int i = 0; i < nwords; i++) begin
            wr_en                  = 1'b1;
            {input_seq, input_ctx} = 2'(s);
            wr_addr                = 4'(i);
            din                    = base + 32'(i);
            blk_op                 = op;
            set_input_ready        = sir_last && (i == nwords - 1);
            tick();
        end
        driveIdle();
    endtask

    task automatic waitOffer(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            if (out_valid === 1'b1) ok = 1'b1;
            else tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL offer_timeout: out_valid=%0b, required 1 within %0d cycles", out_valid, maxc);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        int   s;
        bit   legal;

        RST = 1'b1;
        driveIdle();
        doReset();

        $display("[TB] reset state");
        checkOutput("rst.ready", {28'd0, ready}, 32'hF);
        checkOutput("rst.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst.out_slot", {30'd0, out_slot}, 32'd0);
        checkOutput("rst.out_blk_op", {28'd0, out_blk_op}, 32'd0);
        checkOutput("rst.rd_data", rd_data, 32'd0);
        checkOutput("rst.err", {31'd0, err}, 32'd0);

        // Test 1: load slot 2, offer, read, start, release
        for (int i = 0; i < 16; i++) begin
            v = '0;
            v.wr = 1'b1; v.slot = 2'd2; v.addr = 4'(i); v.din = 32'hA0000000 + 32'(i);
            v.sir = (i == 15); v.op = 4'd1;
            v.e_ready = 4'b1011;
            tbl.push_back(v);
        end
        v = '0; v.rslot = 2'd2; v.raddr = 4'd5; v.e_ready = 4'b1011; v.e_valid = 1'b1;
        v.e_oslot = 2'd2; v.e_op = 4'd1; v.chk_rd = 1'b1; v.e_rd = 32'hA0000005;
        tbl.push_back(v);
        v = '0; v.st = 1'b1; v.rslot = 2'd2; v.raddr = 4'd15; v.e_ready = 4'b1011;
        v.chk_rd = 1'b1; v.e_rd = 32'hA000000F;
        tbl.push_back(v);
        v = '0; v.dn = 1'b1; v.rslot = 2'd2; v.raddr = 4'd0; v.e_ready = 4'b1111;
        v.chk_rd = 1'b1; v.e_rd = 32'hA0000000;
        tbl.push_back(v);
        v = '0; v.e_ready = 4'b1111;
        tbl.push_back(v);

        $display("[TB] test 1: vector table");
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("t1[%0d].ready", i), {28'd0, ready}, {28'd0, tbl[i].e_ready});
            checkOutput($sformatf("t1[%0d].valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
            checkOutput($sformatf("t1[%0d].err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
            if (tbl[i].e_valid) begin
                checkOutput($sformatf("t1[%0d].out_slot", i), {30'd0, out_slot}, {30'd0, tbl[i].e_oslot});
                checkOutput($sformatf("t1[%0d].out_blk_op", i), {28'd0, out_blk_op}, {28'd0, tbl[i].e_op});
            end
            if (tbl[i].chk_rd) begin
                checkOutput($sformatf("t1[%0d].rd_data", i), rd_data, tbl[i].e_rd);
            end
            checkModel($sformatf("t1m[%0d]", i));
        end

        // Test 2: all four slots, round-robin start/done
        $display("[TB] test 2: round-robin");
        doReset();
        for (int k = 0; k < 4; k++) begin
            loadSlot(k, 32'hC0000000 + (32'(k) << 8), 4'(k + 4), 16, 1'b1);
        end
        checkOutput("t2.ready_loaded", {28'd0, ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            waitOffer(8);
            checkOutput($sformatf("t2[%0d].out_slot", k), {30'd0, out_slot}, 32'(k));
            checkOutput($sformatf("t2[%0d].out_blk_op", k), {28'd0, out_blk_op}, 32'(k + 4));
            out_start = 1'b1;
            tick();
            out_start = 1'b0;
            checkOutput($sformatf("t2[%0d].ready_busy", k), {31'd0, ready[k]}, 32'd0);
            rd_slot  = 2'(k);
            out_done = 1'b1;
            tick();
            out_done = 1'b0;
            checkOutput($sformatf("t2[%0d].ready_free", k), {31'd0, ready[k]}, 32'd1);
            checkModel($sformatf("t2m[%0d]", k));
        end
        checkOutput("t2.err", {31'd0, err}, 32'd0);

        // Test 3: early completion after 15 words
        $display("[TB] test 3: early set_input_ready");
        doReset();
        loadSlot(1, 32'hD0000000, 4'd3, 15, 1'b0);
        {input_seq, input_ctx} = 2'd1;
        blk_op          = 4'd3;
        set_input_ready = 1'b1;
        tick();
        driveIdle();
        checkOutput("t3.err", {31'd0, err}, 32'd1);
        checkOutput("t3.ready", {28'd0, ready}, 32'b1101);
        tick();
        checkOutput("t3.no_offer", {31'd0, out_valid}, 32'd0);
        checkModel("t3m");
        wr_en = 1'b1; {input_seq, input_ctx} = 2'd1; wr_addr = 4'd15;
        din = 32'hD000000F; blk_op = 4'd3; set_input_ready = 1'b1;
        tick();
        driveIdle();
        waitOffer(4);
        checkOutput("t3.out_slot", {30'd0, out_slot}, 32'd1);
        checkOutput("t3.out_blk_op", {28'd0, out_blk_op}, 32'd3);
        checkModel("t3m2");

        // Test 4: write into a FULL slot is dropped
        $display("[TB] test 4: write to FULL slot");
        doReset();
        loadSlot(0, 32'hB0000000, 4'd2, 16, 1'b1);
        wr_en = 1'b1; {input_seq, input_ctx} = 2'd0; wr_addr = 4'd3; din = 32'hDEADBEEF;
        tick();
        driveIdle();
        checkOutput("t4.err", {31'd0, err}, 32'd1);
        checkOutput("t4.ready0", {31'd0, ready[0]}, 32'd0);
        waitOffer(4);
        checkOutput("t4.out_slot", {30'd0, out_slot}, 32'd0);
        out_start = 1'b1;
        tick();
        out_start = 1'b0;
        rd_slot = 2'd0; rd_addr = 4'd3;
        tick();
        checkOutput("t4.rd_data", rd_data, 32'hB0000003);
        checkModel("t4m");

        // Test 5: start on slot 3 and done on slot 0 in the same cycle
        $display("[TB] test 5: concurrent start/done");
        doReset();
        loadSlot(0, 32'h50000000, 4'd7, 16, 1'b1);
        loadSlot(3, 32'h53000000, 4'd9, 16, 1'b1);
        waitOffer(4);
        checkOutput("t5.first_slot", {30'd0, out_slot}, 32'd0);
        out_start = 1'b1;
        tick();
        out_start = 1'b0;
        waitOffer(4);
        checkOutput("t5.second_slot", {30'd0, out_slot}, 32'd3);
        checkOutput("t5.second_op", {28'd0, out_blk_op}, 32'd9);
        out_start = 1'b1; out_done = 1'b1; rd_slot = 2'd0;
        tick();
        driveIdle();
        checkOutput("t5.ready", {28'd0, ready}, 32'b0111);
        checkOutput("t5.err", {31'd0, err}, 32'd0);
        tick();
        checkOutput("t5.no_offer", {31'd0, out_valid}, 32'd0);
        checkModel("t5m");

        // Test 6: reset in the middle of a load
        $display("[TB] test 6: reset during load");
        doReset();
        loadSlot(3, 32'hE0000000, 4'd5, 7, 1'b0);
        checkOutput("t6.ready_loading", {28'd0, ready}, 32'b0111);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("t6.ready", {28'd0, ready}, 32'hF);
        checkOutput("t6.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6.out_slot", {30'd0, out_slot}, 32'd0);
        checkOutput("t6.out_blk_op", {28'd0, out_blk_op}, 32'd0);
        checkOutput("t6.err", {31'd0, err}, 32'd0);
        loadSlot(3, 32'hF0000000, 4'd6, 16, 1'b1);
        waitOffer(4);
        checkOutput("t6.out_slot_reload", {30'd0, out_slot}, 32'd3);
        out_start = 1'b1;
        tick();
        out_start = 1'b0;
        for (int i = 0; i < 16; i += 5) begin
            rd_slot = 2'd3; rd_addr = 4'(i);
            tick();
            checkOutput($sformatf("t6.rd[%0d]", i), rd_data, 32'hF0000000 + 32'(i));
        end
        driveIdle();

        // Randomized traffic: first half protocol-legal, second half with misuse
        $display("[TB] random phase");
        doReset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            legal = (cyc < 400);
            driveIdle();
            if (cyc == 600) begin
                RST = 1'b1;
            end else begin
                RST = 1'b0;
                s = int'($urandom_range(3, 0));
                {input_seq, input_ctx} = 2'(s);
                blk_op = 4'($urandom);
                if ($urandom_range(99, 0) < 60 && (!legal || m_st[s] <= 1)) begin
                    wr_en   = 1'b1;
                    wr_addr = 4'($urandom_range(15, 0));
                    din     = $urandom;
                    if (legal) set_input_ready = (m_cnt[s] >= 15) && ($urandom_range(3, 0) != 0);
                end else if (legal && m_st[s] == 1 && m_cnt[s] == 16) begin
                    set_input_ready = ($urandom_range(1, 0) == 1);
                end
                if (!legal && $urandom_range(9, 0) == 0) set_input_ready = 1'b1;
                if (m_valid) out_start = ($urandom_range(1, 0) == 1);
                else if (!legal) out_start = ($urandom_range(19, 0) == 0);
                rd_slot = 2'($urandom_range(3, 0));
                rd_addr = 4'($urandom_range(15, 0));
                if (legal) out_done = (m_st[rd_slot] == 3) && ($urandom_range(9, 0) < 3);
                else       out_done = ($urandom_range(9, 0) < 2);
            end
            tick();
            checkModel($sformatf("rnd%0d", cyc));
        end
        RST = 1'b0;
        driveIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
